if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset; bits [1:0] are zero.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous and active-high.
REQ-004 Port toPC, input, 32, SHALL be the next-PC target from the execute stage (branch/jump/jump-register result).
REQ-005 Port redirectF, input, 1, SHALL indicate that toPC is valid and overrides sequential fetch this cycle.
REQ-006 Port stallF, input, 1, SHALL indicate that the decode stage cannot accept instrOut this cycle.
REQ-007 Port imemReq, output, 1, SHALL be the instruction-memory read request.
REQ-008 Port imemAddr, output, 32, SHALL be the instruction-memory word address, byte-addressed.
REQ-009 Port imemAck, input, 1, SHALL indicate that imemData is valid for the current request.
REQ-010 Port imemData, input, 32, SHALL be the fetched instruction word.
REQ-011 Port instrOut, output, 32, SHALL be the IF/ID instruction register.
REQ-012 Port incrPC, output, 32, SHALL be the IF/ID register holding the address of instrOut plus 4.
REQ-013 Port instrValid, output, 1, SHALL be asserted while instrOut/incrPC hold an unconsumed instruction.

Function
REQ-014 States SHALL be FETCH, DISCARD and HOLD; internal registers SHALL be PC, pendPC, skidInstr and skidPC.
REQ-015 The decode stage consumes an instruction in a cycle with instrValid=1 and stallF=0; the slot is free when instrValid=0 or stallF=0.
REQ-016 imemReq SHALL be 1 in FETCH and DISCARD and 0 in HOLD; imemAddr SHALL equal PC.
REQ-017 imemReq SHALL stay asserted and imemAddr SHALL stay stable until imemAck; a request is never withdrawn.
REQ-018 In FETCH with imemAck=1 and redirectF=0 and the slot free, the block SHALL load instrOut<=imemData, incrPC<=PC+4 and instrValid<=1, and SHALL set PC<=PC+4.
REQ-019 In FETCH with imemAck=1 and redirectF=0 and the slot occupied and stalled, the block SHALL set skidInstr<=imemData, skidPC<=PC+4 and PC<=PC+4, then go to HOLD.
REQ-020 In FETCH with imemAck=0 and a consumption occurring, the block SHALL clear instrValid.
REQ-021 In FETCH with redirectF=1, the block SHALL clear instrValid.
  - If imemAck=1: drop the response, set PC<=toPC with bits [1:0] forced to 00, stay in FETCH.
  - If imemAck=0: set pendPC<=toPC with bits [1:0] forced to 00, go to DISCARD.
REQ-022 In DISCARD, on imemAck the block SHALL drop the response, set PC<=pendPC and go to FETCH.
  - A redirectF in DISCARD SHALL overwrite pendPC.
  - instrValid SHALL stay 0 throughout DISCARD.
REQ-023 In HOLD with redirectF=1, the block SHALL discard the skid, clear instrValid, set PC<=toPC (bits [1:0] forced to 00) and go to FETCH.
REQ-024 In HOLD with redirectF=0 and stallF=0, the block SHALL load instrOut<=skidInstr, incrPC<=skidPC and instrValid<=1, then go to FETCH.
REQ-025 redirectF SHALL take priority over stallF and imemAck in every state.
REQ-026 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 With zero-wait memory (imemAck=1 in the request cycle) and no stall, throughput SHALL be one instruction per cycle, with instrOut valid one cycle after the request.

Reset
REQ-028 While rst=1, the block SHALL hold imemReq=0.
REQ-029 On rst, the block SHALL set PC<=RESET_PC, pendPC/skidInstr/skidPC/instrOut/incrPC<=0, instrValid<=0 and state<=FETCH.
REQ-030 Reset mid-request SHALL abandon the outstanding request; no response SHALL be captured in the reset cycle.
REQ-031 In the first cycle after rst deasserts, imemReq SHALL be 1 and imemAddr SHALL equal RESET_PC.

Verification
REQ-032 Reset, zero-wait memory, no stall -> imemAddr sequence 0,4,8,C; instrOut matches each word one cycle later; incrPC = 4,8,C,10.
REQ-033 At PC=0x10, stallF=1 for 3 cycles with ack -> instrOut holds; skid captures the 0x14 word; imemReq=0 in HOLD; on release instrOut=word@0x14 and fetch resumes at 0x18.
REQ-034 At PC=0x20, imemAck delayed 2 cycles, redirectF with toPC=0x103 before ack -> 0x20 response dropped; instrValid=0; next imemAddr=0x100.
REQ-035 redirectF with toPC=0x40 in the same cycle as imemAck, with stallF=1 -> instrValid=0; next imemAddr=0x40; no stale instruction delivered.
REQ-036 PC=0xFFFF_FFFC fetched, then rst asserted during a delayed-ack request -> next imemAddr wraps to 0, then after reset imemAddr=RESET_PC with instrValid=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: sequential/redirected PC generation, single outstanding
// instruction-memory request, and the IF/ID register with a one-entry skid buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] toPC,
  input  logic        redirectF,
  input  logic        stallF,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instrOut,
  output logic [31:0] incrPC,
  output logic        instrValid
);

  typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] incr_q, incr_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        slot_free;

  assign pc_plus4  = pc_q + 32'd4;
  assign target    = toPC & ~32'h3;
  assign slot_free = !valid_q || !stallF;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    incr_d       = incr_q;
    valid_d      = valid_q;
    case (state_q)
      FETCH: begin
        if (redirectF) begin
          valid_d = 1'b0;
          if (imemAck) begin
            pc_d = target;
          end else begin
            // The in-flight request cannot be withdrawn; its response is dropped later.
            pend_pc_d = target;
            state_d   = DISCARD;
          end
        end else if (imemAck) begin
          pc_d = pc_plus4;
          if (slot_free) begin
            instr_d = imemData;
            incr_d  = pc_plus4;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = imemData;
            skid_pc_d    = pc_plus4;
            state_d      = HOLD;
          end
        end else if (valid_q && !stallF) begin
          valid_d = 1'b0;
        end
      end
      DISCARD: begin
        if (redirectF && imemAck) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (redirectF) begin
          pend_pc_d = target;
        end else if (imemAck) begin
          pc_d    = pend_pc_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirectF) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = FETCH;
        end else if (!stallF) begin
          instr_d = skid_instr_q;
          incr_d  = skid_pc_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= '0;
      incr_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      incr_q       <= incr_d;
      valid_q      <= valid_d;
    end
  end

  // Request is gated by rst so nothing is issued during the reset cycle itself.
  assign imemReq    = !rst && (state_q != HOLD);
  assign imemAddr   = pc_q;
  assign instrOut   = instr_q;
  assign incrPC     = incr_q;
  assign instrValid = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by a randomized run scored
// against the expected in-order delivered-instruction stream.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] toPC;
  logic        redirectF;
  logic        stallF;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instrOut;
  logic [31:0] incrPC;
  logic        instrValid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .toPC(toPC), .redirectF(redirectF), .stallF(stallF),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instrOut(instrOut), .incrPC(incrPC), .instrValid(instrValid)
  );

  // Instruction memory contents: a distinct word for every address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, and return #1 after the edge.
  task automatic drive(input logic r, input logic rd, input logic [31:0] tp,
                       input logic st, input logic ak);
    rst       = r;
    redirectF = rd;
    toPC      = tp;
    stallF    = st;
    imemAck   = ak;
    imemData  = ak ? memw(imemAddr) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] prev_addr;
  logic        prev_pend;
  logic        st, rd, ak;
  logic [31:0] tp;
  int          n_cons;

  initial begin
    rst = 1'b1; redirectF = 1'b0; toPC = '0; stallF = 1'b0; imemAck = 1'b0; imemData = '0;

    // Reset, including an ack presented during reset that must not be captured.
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    check_eq("rst_req",   32'(imemReq), 32'd0);
    check_eq("rst_valid", 32'(instrValid), 32'd0);
    check_eq("rst_instr", instrOut, 32'd0);
    check_eq("rst_incr",  incrPC, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_req",  32'(imemReq), 32'd1);
    check_eq("post_rst_addr", imemAddr, 32'h0);

    // Zero-wait streaming, one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_addr", imemAddr, 32'(4 * i));
      drive(0, 0, 0, 0, 1);
      check_eq("seq_instr", instrOut, memw(32'(4 * i)));
      check_eq("seq_incr",  incrPC, 32'(4 * i + 4));
      check_eq("seq_valid", 32'(instrValid), 32'd1);
    end

    // Stall with ack: the 0x14 word goes to the skid, fetch pauses in HOLD.
    drive(0, 0, 0, 0, 1);
    check_eq("w10_instr", instrOut, memw(32'h10));
    drive(0, 0, 0, 1, 1);
    check_eq("hold_instr", instrOut, memw(32'h10));
    check_eq("hold_req",   32'(imemReq), 32'd0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    check_eq("hold3_instr", instrOut, memw(32'h10));
    check_eq("hold3_req",   32'(imemReq), 32'd0);
    check_eq("hold3_valid", 32'(instrValid), 32'd1);
    drive(0, 0, 0, 0, 0);
    check_eq("skid_instr", instrOut, memw(32'h14));
    check_eq("skid_incr",  incrPC, 32'h18);
    check_eq("skid_addr",  imemAddr, 32'h18);
    check_eq("skid_req",   32'(imemReq), 32'd1);

    // Delayed ack at 0x20 with redirect before the ack.
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    check_eq("at20_addr", imemAddr, 32'h20);
    drive(0, 0, 0, 0, 0);
    check_eq("wait_valid", 32'(instrValid), 32'd0);
    check_eq("wait_addr",  imemAddr, 32'h20);
    drive(0, 1, 32'h103, 0, 0);
    check_eq("disc_valid", 32'(instrValid), 32'd0);
    check_eq("disc_addr",  imemAddr, 32'h20);
    check_eq("disc_req",   32'(imemReq), 32'd1);
    drive(0, 0, 0, 0, 1);
    check_eq("redir_valid", 32'(instrValid), 32'd0);
    check_eq("redir_addr",  imemAddr, 32'h100);

    // Redirect coinciding with ack while stalled.
    drive(0, 0, 0, 0, 1);
    check_eq("w100_instr", instrOut, memw(32'h100));
    drive(0, 1, 32'h40, 1, 1);
    check_eq("rs_valid", 32'(instrValid), 32'd0);
    check_eq("rs_addr",  imemAddr, 32'h40);
    drive(0, 0, 0, 0, 1);
    check_eq("w40_instr", instrOut, memw(32'h40));
    check_eq("w40_incr",  incrPC, 32'h44);

    // PC wrap, then reset during a delayed-ack request.
    drive(0, 1, 32'hFFFF_FFFE, 0, 1);
    check_eq("top_addr", imemAddr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 1);
    check_eq("wrap_instr", instrOut, memw(32'hFFFF_FFFC));
    check_eq("wrap_incr",  incrPC, 32'h0);
    check_eq("wrap_addr",  imemAddr, 32'h0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1);
    check_eq("mrst_valid", 32'(instrValid), 32'd0);
    check_eq("mrst_instr", instrOut, 32'd0);
    check_eq("mrst_req",   32'(imemReq), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("mrst_addr",    imemAddr, 32'h0);
    check_eq("mrst_req_out", 32'(imemReq), 32'd1);

    // Randomized run: delivered instructions must follow the architectural stream.
    exp_pc    = 32'h0;
    prev_pend = 1'b0;
    prev_addr = '0;
    n_cons    = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_pend) begin
        check_eq("rq_held", 32'(imemReq), 32'd1);
        check_eq("rq_addr", imemAddr, prev_addr);
      end
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 19) == 0);
      tp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : ($urandom & 32'h0000_0FFF);
      ak = imemReq && ($urandom_range(0, 9) < 6);
      rst       = 1'b0;
      redirectF = rd;
      stallF    = st;
      toPC      = tp;
      imemAck   = ak;
      imemData  = ak ? memw(imemAddr) : $urandom;
      if (instrValid && !st && !rd) begin
        check_eq("rnd_pc",    incrPC - 32'd4, exp_pc);
        check_eq("rnd_instr", instrOut, memw(incrPC - 32'd4));
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end
      if (rd) exp_pc = tp & ~32'h3;
      prev_pend = imemReq && !ak;
      prev_addr = imemAddr;
      @(posedge clk);
      #1;
    end
    check_eq("rnd_progress", 32'(n_cons > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
